// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity support in uart_rx is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so an idle line never looks active.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // metastability filter: d_i -> s1 -> s2
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with full/ack host handshake and sticky errors.
// Define UART_RX_PARITY_EN to add a parity bit and parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT = CLKS_PER_BIT / 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxD,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       rdrf,
  output logic       frame_err,
  output logic       oe,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [15:0] HALF_M1 = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_t state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic rdrf_q, rdrf_d;
  logic fe_q, fe_d;
  logic oe_q, oe_d;
`ifdef UART_RX_PARITY_EN
  logic pe_q, pe_d;
`endif
  logic rx_s;
  logic tick_half;
  logic tick_bit;

  uart_rx_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .clr(clr),
    .d_i(rxD),
    .q_o(rx_s)
  );

  assign tick_half = (baud_q == HALF_M1);
  assign tick_bit = (baud_q == BIT_M1);

  // state, counters and host-visible registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      rdrf_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      rdrf_q <= rdrf_d;
      fe_q <= fe_d;
      oe_q <= oe_d;
`ifdef UART_RX_PARITY_EN
      pe_q <= pe_d;
`endif
    end
  end

  // frame sequencing; ack clears first so new errors override it
  always_comb begin
    state_d = state_q;
    baud_d = baud_q + 16'd1;
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = data_q;
    rdrf_d = rdrf_q;
    fe_d = fe_q;
    oe_d = oe_q;
`ifdef UART_RX_PARITY_EN
    pe_d = pe_q;
`endif

    if (rd_ack) begin
      rdrf_d = 1'b0;
      fe_d = 1'b0;
      oe_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (tick_half) begin
          if (!rx_s) begin
            state_d = DATA;
            bit_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_bit) begin
          baud_d = '0;
          sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick_bit) begin
          if (rx_s != ((^sh_q) ^ PARITY_ODD)) pe_d = 1'b1;
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (tick_bit) begin
          if (rx_s) begin
            if (!rdrf_q || rd_ack) begin
              data_d = sh_q;
              rdrf_d = 1'b1;
            end else begin
              oe_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            fe_d = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        baud_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) baud_d = '0;
  end

  assign rx_data = data_q;
  assign rdrf = rdrf_q;
  assign frame_err = fe_q;
  assign oe = oe_q;
  assign busy = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random traffic
// compared against a host-side register model of the receiver.
module tb_uart_rx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic rxD = 1'b1;
  logic rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic rdrf;
  logic frame_err;
  logic oe;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .clr(clr),
    .rxD(rxD),
    .rd_ack(rd_ack),
    .rx_data(rx_data),
    .rdrf(rdrf),
    .frame_err(frame_err),
    .oe(oe),
    .busy(busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_data;
  logic m_rdrf;
  logic m_fe;
  logic m_oe;
  logic m_pe;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_busy);
    chk({tag, "_data"}, rx_data, m_data);
    chk({tag, "_rdrf"}, 8'(rdrf), 8'(m_rdrf));
    chk({tag, "_fe"}, 8'(frame_err), 8'(m_fe));
    chk({tag, "_oe"}, 8'(oe), 8'(m_oe));
    chk({tag, "_busy"}, 8'(busy), 8'(exp_busy));
`ifdef UART_RX_PARITY_EN
    chk({tag, "_pe"}, 8'(parity_err), 8'(m_pe));
`endif
  endtask

  task automatic m_reset();
    m_data = 8'h00;
    m_rdrf = 1'b0;
    m_fe = 1'b0;
    m_oe = 1'b0;
    m_pe = 1'b0;
  endtask

  task automatic do_ack();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    m_rdrf = 1'b0;
    m_fe = 1'b0;
    m_oe = 1'b0;
    m_pe = 1'b0;
  endtask

  // Drives one whole frame; returns #1 after the edge where the stop
  // bit is judged. ack_commit raises rd_ack for exactly that edge.
  task automatic send(input logic [7:0] b, input logic stop_bit,
                      input logic par_bit, input bit ack_commit);
    logic bits[$];
    logic prev;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(par_bit);
`endif
    bits.push_back(stop_bit);
    for (int i = 0; i < bits.size(); i++) begin
      rxD = bits[i];
      repeat (CPB) step();
    end
    if (!m_rdrf) chk("early_rdrf", 8'(rdrf), 8'h00);
    rd_ack = ack_commit;
    step();
    rd_ack = 1'b0;
    prev = m_rdrf;
    if (ack_commit) begin
      m_rdrf = 1'b0;
      m_fe = 1'b0;
      m_oe = 1'b0;
      m_pe = 1'b0;
    end
`ifdef UART_RX_PARITY_EN
    if (par_bit != ^b) m_pe = 1'b1;
`else
    if (par_bit) m_pe = m_pe;
`endif
    if (stop_bit) begin
      if (!prev || ack_commit) begin
        m_data = b;
        m_rdrf = 1'b1;
      end else begin
        m_oe = 1'b1;
      end
    end else begin
      m_fe = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic rstop;
    bit rack;
    logic [7:0] ab;

    m_reset();
    repeat (3) step();
    clr = 1'b0;
    chk_all("reset", 1'b0);

    send(8'hA5, 1'b1, ^8'hA5, 1'b0);
    chk_all("a5", 1'b0);
    do_ack();
    chk_all("a5_ack", 1'b0);

    rxD = 1'b0;
    step();
    rxD = 1'b1;
    step();
    step();
    chk("glitch_busy_hi", 8'(busy), 8'h01);
    repeat (3) step();
    chk_all("glitch", 1'b0);

    send(8'h3C, 1'b0, ^8'h3C, 1'b0);
    chk_all("brk_enter", 1'b1);
    repeat (20) step();
    chk_all("brk_hold", 1'b1);
    rxD = 1'b1;
    repeat (5) step();
    chk_all("brk_exit", 1'b0);
    send(8'h3C, 1'b1, ^8'h3C, 1'b0);
    chk_all("3c", 1'b0);
    do_ack();

    repeat (2) step();
    send(8'h11, 1'b1, ^8'h11, 1'b0);
    chk_all("11", 1'b0);
    repeat (2) step();
    send(8'h22, 1'b1, ^8'h22, 1'b0);
    chk_all("22_overrun", 1'b0);
    repeat (2) step();
    send(8'h55, 1'b1, ^8'h55, 1'b1);
    chk_all("55_ackcommit", 1'b0);

    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) do_ack();
      repeat ($urandom_range(1, 6)) step();
      send(rb, rstop, ^rb, rack);
      chk_all("rand", !rstop);
      if (!rstop) begin
        rxD = 1'b1;
        repeat (4) step();
      end
    end

    do_ack();
    send(8'h99, 1'b1, ^8'h99, 1'b0);
    repeat (2) step();
    ab = 8'h81;
    rxD = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 3; i++) begin
      rxD = ab[i];
      repeat (CPB) step();
    end
    rxD = ab[3];
    repeat (2) step();
    clr = 1'b1;
    rxD = 1'b1;
    step();
    clr = 1'b0;
    m_reset();
    chk_all("clr_abort", 1'b0);
    repeat (4) step();
    send(8'h0F, 1'b1, ^8'h0F, 1'b0);
    chk_all("0f", 1'b0);

`ifdef UART_RX_PARITY_EN
    do_ack();
    repeat (2) step();
    send(8'h07, 1'b1, 1'b0, 1'b0);
    chk_all("par_07", 1'b0);
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
